// File: rtl/syc_fifo_pkg.sv
// -----------------------------------------------------------------------------
// syc_fifo_pkg
// Shared helpers for the syc_fifo_flags FIFO.
// It derives the address and pointer widths from DEPTH and provides the
// parameter-legality checks that the top level evaluates at elaboration.
// -----------------------------------------------------------------------------
package syc_fifo_pkg;

  // Address bits needed to index DEPTH entries.
  function automatic int addr_width(input int depth);
    return $clog2(depth);
  endfunction

  // Pointer width: the address bits plus one wrap bit.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // DEPTH must be a power of two and at least 2.
  function automatic bit depth_ok(input int depth);
    return (depth >= 32'sd2) && ((depth & (depth - 32'sd1)) == 32'sd0);
  endfunction

  // almost_full threshold must be 1..DEPTH, almost_empty 0..DEPTH-1.
  function automatic bit thresholds_ok(input int depth, input int afull_th,
                                       input int aempty_th);
    return (afull_th >= 32'sd1) && (afull_th <= depth) &&
           (aempty_th >= 32'sd0) && (aempty_th <= (depth - 32'sd1));
  endfunction

endpackage

// File: rtl/syc_fifo_mem.sv
// -----------------------------------------------------------------------------
// syc_fifo_mem
// DEPTH x DATA_WIDTH register array: synchronous write, asynchronous read,
// no reset on the storage.
// Ports:
//   i_clk    clock, rising edge
//   i_we     write enable
//   i_waddr  write address
//   i_wdata  write word
//   i_raddr  read address
//   o_rdata  read word (combinational from i_raddr)
// -----------------------------------------------------------------------------
module syc_fifo_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // Storage write; contents are deliberately left unreset.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/syc_fifo_flags.sv
// -----------------------------------------------------------------------------
// syc_fifo_flags
// Single-clock FIFO with selectable read mode (registered or FWFT),
// programmable almost-full/almost-empty thresholds, occupancy count,
// sticky overflow/underflow flags and a synchronous flush.
// Ports:
//   clk           clock, rising edge
//   rstb          asynchronous active-low reset
//   flush         synchronous clear of pointers, error flags (and rd_data when FWFT=0)
//   wr_en/wr_data write request and word
//   rd_en         read request (in FWFT mode: consume head)
//   rd_data       read word
//   full/empty    count == DEPTH / count == 0
//   almost_full   count >= AFULL_TH
//   almost_empty  count <= AEMPTY_TH
//   count         occupancy 0..DEPTH
//   overflow      sticky: a write was rejected
//   underflow     sticky: a read was rejected
// -----------------------------------------------------------------------------
module syc_fifo_flags
  import syc_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int FWFT       = 0,
  parameter int AFULL_TH   = DEPTH - 2,
  parameter int AEMPTY_TH  = 2
) (
  input  logic                  clk,
  input  logic                  rstb,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int ADDR_WIDTH = addr_width(DEPTH);
  localparam int PTR_WIDTH  = ptr_width(DEPTH);

  localparam logic [PTR_WIDTH-1:0] PTR_ONE   = {{(PTR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [PTR_WIDTH-1:0] CNT_FULL  = PTR_WIDTH'(DEPTH);
  localparam logic [PTR_WIDTH-1:0] CNT_AFULL = PTR_WIDTH'(AFULL_TH);
  localparam logic [PTR_WIDTH-1:0] CNT_AEMPT = PTR_WIDTH'(AEMPTY_TH);

  // Elaboration-time parameter checks.
  if (!depth_ok(DEPTH)) begin : g_bad_depth
    $error("syc_fifo_flags: DEPTH must be a power of 2 and >= 2");
  end
  if (!thresholds_ok(DEPTH, AFULL_TH, AEMPTY_TH)) begin : g_bad_th
    $error("syc_fifo_flags: AFULL_TH or AEMPTY_TH out of range");
  end

  logic [PTR_WIDTH-1:0]  r_wr_ptr;
  logic [PTR_WIDTH-1:0]  r_rd_ptr;
  logic                  r_overflow;
  logic                  r_underflow;
  logic [PTR_WIDTH-1:0]  w_count;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic [DATA_WIDTH-1:0] w_head;

  // Occupancy is the modular pointer difference; the wrap bit separates
  // full from empty when the address bits match.
  assign w_count = r_wr_ptr - r_rd_ptr;
  assign w_full  = (w_count == CNT_FULL);
  assign w_empty = (w_count == {PTR_WIDTH{1'b0}});

  // A write while full is taken only alongside a read (which is accepted,
  // since full implies not empty). No bypass: a read while empty is refused.
  assign w_rd_acc = rd_en && !w_empty;
  assign w_wr_acc = wr_en && (!w_full || rd_en);

  assign count        = w_count;
  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (w_count >= CNT_AFULL);
  assign almost_empty = (w_count <= CNT_AEMPT);
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

  // Write and read pointers; flush outranks any request in the same cycle.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_wr_ptr <= {PTR_WIDTH{1'b0}};
      r_rd_ptr <= {PTR_WIDTH{1'b0}};
    end else if (flush) begin
      r_wr_ptr <= {PTR_WIDTH{1'b0}};
      r_rd_ptr <= {PTR_WIDTH{1'b0}};
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_rd_acc) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
    end
  end

  // Sticky error flags, cleared only by reset or flush.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (flush) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (wr_en && !w_wr_acc) begin
        r_overflow <= 1'b1;
      end
      if (rd_en && w_empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

  syc_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .i_clk   (clk),
    .i_we    (w_wr_acc && !flush),
    .i_waddr (r_wr_ptr[ADDR_WIDTH-1:0]),
    .i_wdata (wr_data),
    .i_raddr (r_rd_ptr[ADDR_WIDTH-1:0]),
    .o_rdata (w_head)
  );

  if (FWFT != 0) begin : g_fwft
    // Head word falls through; meaningless while empty.
    assign rd_data = w_head;
  end else begin : g_reg_read
    logic [DATA_WIDTH-1:0] r_rd_data;

    // Registered read: capture the old head on an accepted read. When full
    // and writing the same slot, the memory still holds the old word here.
    always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
        r_rd_data <= {DATA_WIDTH{1'b0}};
      end else if (flush) begin
        r_rd_data <= {DATA_WIDTH{1'b0}};
      end else if (w_rd_acc) begin
        r_rd_data <= w_head;
      end else begin
        r_rd_data <= r_rd_data;
      end
    end

    assign rd_data = r_rd_data;
  end

endmodule

// File: tb/tb_syc_fifo_flags.sv
// -----------------------------------------------------------------------------
// tb_syc_fifo_flags
// Directed bench: two FIFOs (registered read and FWFT) driven by the same
// stimulus, DEPTH=8, AFULL_TH=6, AEMPTY_TH=2.
// -----------------------------------------------------------------------------
module tb_syc_fifo_flags;

  logic        clk;
  logic        rstb;
  logic        flush;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        rd_en;

  logic [31:0] rd_data0, rd_data1;
  logic        full0, empty0, af0, ae0, ov0, un0;
  logic        full1, empty1, af1, ae1, ov1, un1;
  logic [3:0]  count0, count1;

  int n_checks = 0;
  int n_errors = 0;

  syc_fifo_flags #(.DATA_WIDTH(32), .DEPTH(8), .FWFT(0), .AFULL_TH(6), .AEMPTY_TH(2)) u_dut_reg (
    .clk(clk), .rstb(rstb), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
    .rd_en(rd_en), .rd_data(rd_data0), .full(full0), .empty(empty0),
    .almost_full(af0), .almost_empty(ae0), .count(count0),
    .overflow(ov0), .underflow(un0)
  );

  syc_fifo_flags #(.DATA_WIDTH(32), .DEPTH(8), .FWFT(1), .AFULL_TH(6), .AEMPTY_TH(2)) u_dut_fwft (
    .clk(clk), .rstb(rstb), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
    .rd_en(rd_en), .rd_data(rd_data1), .full(full1), .empty(empty1),
    .almost_full(af1), .almost_empty(ae1), .count(count1),
    .overflow(ov1), .underflow(un1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock with the given requests; outputs are sampled 1 time unit later.
  task automatic cyc(input logic we, input logic [31:0] wd, input logic re);
    wr_en   = we;
    wr_data = wd;
    rd_en   = re;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    wr_en = 1'b1;
    rd_en = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_count"}, {28'd0, count0}, 32'd0);
    chk({tag, "_empty"}, {31'd0, empty0}, 32'd1);
    chk({tag, "_full"},  {31'd0, full0},  32'd0);
    chk({tag, "_ae"},    {31'd0, ae0},    32'd1);
    chk({tag, "_af"},    {31'd0, af0},    32'd0);
    chk({tag, "_ov"},    {31'd0, ov0},    32'd0);
    chk({tag, "_un"},    {31'd0, un0},    32'd0);
    chk({tag, "_rd"},    rd_data0,        32'd0);
    chk({tag, "_empty1"}, {31'd0, empty1}, 32'd1);
  endtask

  initial begin
    logic [31:0] exp_w;
    rstb    = 1'b0;
    flush   = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    wr_data = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_state("rst");
    rstb = 1'b1;

    // Fill 0xA0..0xA7: count and threshold flags step up.
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 32'hA0 + 32'(i), 1'b0);
      chk("fill_count", {28'd0, count0}, 32'(i + 1));
      chk("fill_empty", {31'd0, empty0}, 32'd0);
      chk("fill_ae", {31'd0, ae0}, ((i + 1) <= 2) ? 32'd1 : 32'd0);
      chk("fill_af", {31'd0, af0}, ((i + 1) >= 6) ? 32'd1 : 32'd0);
      chk("fill_full", {31'd0, full0}, ((i + 1) == 8) ? 32'd1 : 32'd0);
      chk("fill_fwft_head", rd_data1, 32'hA0);
    end

    // Drain: registered read shows each word one cycle after its rd_en edge.
    for (int i = 0; i < 8; i++) begin
      chk("drain_fwft_head", rd_data1, 32'hA0 + 32'(i));
      cyc(1'b0, 32'd0, 1'b1);
      chk("drain_rd", rd_data0, 32'hA0 + 32'(i));
      chk("drain_count", {28'd0, count0}, 32'(7 - i));
    end
    chk("drain_empty", {31'd0, empty0}, 32'd1);

    // Ninth read: refused, underflow sticks, rd_data holds.
    cyc(1'b0, 32'd0, 1'b1);
    chk("uf_flag", {31'd0, un0}, 32'd1);
    chk("uf_flag1", {31'd0, un1}, 32'd1);
    chk("uf_hold", rd_data0, 32'hA7);
    chk("uf_count", {28'd0, count0}, 32'd0);
    do_flush();
    chk("uf_flush", {31'd0, un0}, 32'd0);

    // FWFT: a write into the empty FIFO appears on the next cycle.
    cyc(1'b1, 32'h55, 1'b0);
    chk("fwft_data", rd_data1, 32'h55);
    chk("fwft_nempty", {31'd0, empty1}, 32'd0);
    cyc(1'b0, 32'd0, 1'b1);
    chk("fwft_empty", {31'd0, empty1}, 32'd1);
    chk("fwft_reg_rd", rd_data0, 32'h55);

    // Full, then simultaneous write+read keeps count at DEPTH.
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 32'hC0 + 32'(i), 1'b0);
    end
    chk("full_flag", {31'd0, full0}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("wr_rd_fwft_head", rd_data1, 32'hC0 + 32'(i));
      cyc(1'b1, 32'hB0 + 32'(i), 1'b1);
      chk("wr_rd_data", rd_data0, 32'hC0 + 32'(i));
      chk("wr_rd_count", {28'd0, count0}, 32'd8);
      chk("wr_rd_ov", {31'd0, ov0}, 32'd0);
    end
    cyc(1'b1, 32'hEE, 1'b0);
    chk("ov_flag", {31'd0, ov0}, 32'd1);
    chk("ov_count", {28'd0, count0}, 32'd8);
    for (int i = 0; i < 8; i++) begin
      exp_w = (i < 4) ? (32'hC4 + 32'(i)) : (32'hB0 + 32'(i - 4));
      chk("order_fwft", rd_data1, exp_w);
      cyc(1'b0, 32'd0, 1'b1);
      chk("order_reg", rd_data0, exp_w);
    end
    chk("order_empty", {31'd0, empty0}, 32'd1);
    do_flush();

    // Streaming 20 words with one in flight: addresses wrap twice.
    cyc(1'b1, 32'h100, 1'b0);
    for (int k = 1; k < 20; k++) begin
      cyc(1'b1, 32'h100 + 32'(k), 1'b1);
      chk("stream_rd", rd_data0, 32'h100 + 32'(k - 1));
      chk("stream_fwft", rd_data1, 32'h100 + 32'(k));
      chk("stream_count", {28'd0, count0}, 32'd1);
    end
    cyc(1'b0, 32'd0, 1'b1);
    chk("stream_last", rd_data0, 32'h113);
    chk("stream_un", {31'd0, un0}, 32'd0);
    cyc(1'b0, 32'd0, 1'b1);
    chk("stream_uf", {31'd0, un0}, 32'd1);
    do_flush();
    chk("flush_count", {28'd0, count0}, 32'd0);
    chk("flush_empty", {31'd0, empty0}, 32'd1);
    chk("flush_ov", {31'd0, ov0}, 32'd0);
    chk("flush_un", {31'd0, un0}, 32'd0);
    chk("flush_rd", rd_data0, 32'd0);

    // Reset with count=5 and overflow set acts without a clock edge.
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 32'hE0 + 32'(i), 1'b0);
    end
    cyc(1'b1, 32'hFF, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 32'd0, 1'b1);
    end
    chk("pre_rst_count", {28'd0, count0}, 32'd5);
    chk("pre_rst_ov", {31'd0, ov0}, 32'd1);
    chk("pre_rst_rd", rd_data0, 32'hE2);
    #2;
    rstb = 1'b0;
    #1;
    chk_reset_state("async_rst");
    @(posedge clk);
    #1;
    rstb = 1'b1;
    cyc(1'b1, 32'h3C, 1'b0);
    chk("post_rst_fwft", rd_data1, 32'h3C);
    chk("post_rst_count", {28'd0, count0}, 32'd1);
    cyc(1'b0, 32'd0, 1'b1);
    chk("post_rst_rd", rd_data0, 32'h3C);
    chk("post_rst_empty", {31'd0, empty0}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/syc_fifo_flags.md
Name: syc_fifo_flags

Overview:
Parametrised synchronous FIFO. It is the next-generation single-clock buffer for the datapath.
- Adds a selectable read mode: registered read, or first-word-fall-through (FWFT).
- Adds programmable almost-full / almost-empty thresholds and an occupancy count.
- Adds sticky overflow/underflow error flags and a synchronous flush.
- Sits between producer/consumer stages that need back-pressure earlier than hard full/empty.

Parameters:
- DATA_WIDTH, 32: word width in bits.
- DEPTH, 8: number of entries. Must be a power of 2 and ≥ 2.
- FWFT, 0: read mode.
  - 0 = registered read: rd_data updates 1 cycle after an accepted read.
  - 1 = first-word-fall-through: rd_data shows the head word whenever !empty.
- AFULL_TH, DEPTH-2: almost_full asserts when count ≥ AFULL_TH. Legal range 1..DEPTH.
- AEMPTY_TH, 2: almost_empty asserts when count ≤ AEMPTY_TH. Legal range 0..DEPTH-1.

Ports:
- clk  input  1  clock, rising edge.
- rstb  input  1  asynchronous active-low reset.
- flush  input  1  synchronous clear of pointers and error flags.
- wr_en  input  1  write request.
- wr_data  input  DATA_WIDTH  write word.
- rd_en  input  1  read request.
- rd_data  output  DATA_WIDTH  read word; timing depends on FWFT.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- almost_full  output  1  count ≥ AFULL_TH.
- almost_empty  output  1  count ≤ AEMPTY_TH.
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky: a write was rejected.
- underflow  output  1  sticky: a read was rejected.

Behaviour:
- Clock and reset: one clock, clk. Reset rstb is asynchronous, active-low.
- Reset mid-operation acts immediately. It clears:
  - wr_ptr, rd_ptr, overflow, underflow;
  - rd_data (FWFT=0 only).
- Memory contents are not reset.
- Values out of reset: count=0, empty=1, full=0, almost_empty=1, almost_full=0 (given AFULL_TH ≥ 1).
- Pointers are ADDR_WIDTH+1 bits; the MSB is a wrap bit.
  - count = wr_ptr − rd_ptr, modulo 2^(ADDR_WIDTH+1).
  - All flags are combinational decodes of the registered pointers, so they are glitch-free relative to clk.
- rd_acc = rd_en && !empty.
- wr_acc = wr_en && (!full || rd_en).
  - A write while full is accepted only if a read is accepted in the same cycle; count stays DEPTH.
  - While empty, a simultaneous wr_en+rd_en accepts the write and rejects the read (no bypass); underflow sets.
- wr_acc: mem[wr_ptr[ADDR_WIDTH-1:0]] ← wr_data; wr_ptr increments, wrapping naturally.
- rd_acc: rd_ptr increments.
- FWFT=0: on rd_acc, rd_data ← mem[rd_ptr] (old head). Otherwise rd_data holds its value.
- FWFT=1:
  - rd_data = mem[rd_ptr] combinationally. The first write becomes visible the cycle after wr_acc.
  - rd_data is don't-care while empty.
  - rd_en acts as "consume head".
- Same-slot read and write when full: the read returns the old word and the write lands afterwards.
- Count and flag update: count changes by +1 (write only), −1 (read only) or 0 (both or none). Flags update the cycle after the accepting edge.
- Error flags:
  - overflow ← 1 on wr_en && !wr_acc.
  - underflow ← 1 on rd_en && empty.
  - Both hold until flush or reset.
- flush has the highest priority:
  - Clears wr_ptr, rd_ptr, overflow and underflow; clears rd_data when FWFT=0.
  - wr_en/rd_en in the flush cycle are ignored and not flagged.
- No internal state machine beyond the pointers: occupancy is fully defined by (wr_ptr, rd_ptr).

Decomposition:
- Package syc_fifo_pkg holds:
  - the ADDR_WIDTH/PTR_WIDTH derivation;
  - elaboration checks: DEPTH is a power of 2; thresholds are in range.
- Sub-module syc_fifo_mem: DEPTH×DATA_WIDTH register array with synchronous write and asynchronous read, no reset.
- The top level contains pointers, flags, error logic and the read-mode generate.

Test Plan:
All scenarios use DEPTH=8, AFULL_TH=6, AEMPTY_TH=2.
- Write 1..8 with no reads -> count steps 1..8; almost_empty drops at count=3; almost_full rises at count=6; full=1 at 8; empty=0 after the first write.
- FWFT=0: fill with 0xA0..0xA7, then read 8 times -> rd_data shows 0xA0..0xA7, each 1 cycle after its rd_en edge; empty=1 after the 8th read. A 9th rd_en sets underflow, and rd_data holds 0xA7.
- FWFT=1: write 0x55 into the empty FIFO -> rd_data=0x55 on the next cycle with no rd_en. rd_en for 1 cycle -> empty=1.
- Full, then wr_en+rd_en together for 4 cycles with 0xB0..0xB3 -> count stays 8, overflow=0, and the data order is preserved. Then wr_en alone -> overflow=1, count=8.
- Continuous streaming of 20 words with simultaneous read/write -> the pointers wrap twice and the data emerges in order. Then assert flush -> count=0, empty=1, overflow=underflow=0 the next cycle.
- Reset while count=5 with overflow=1 -> all outputs return to their reset values immediately. Then a write+read of 0x3C returns 0x3C.
